// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing (800x600 @ 60 Hz, 40 MHz pixel clock),
// default display-window geometry and the shared coordinate type.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned H_FP_DEF     = 40;
  localparam int unsigned H_SYNC_DEF   = 128;
  localparam int unsigned H_BP_DEF     = 88;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 600;
  localparam int unsigned V_FP_DEF     = 1;
  localparam int unsigned V_SYNC_DEF   = 4;
  localparam int unsigned V_BP_DEF     = 23;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned WIN_W_DEF    = 300;
  localparam int unsigned WIN_H_DEF    = 300;

  // Wide enough for H_TOTAL_DEF-1 and V_TOTAL_DEF-1
  localparam int unsigned CW_DEF       = 11;

  typedef logic [CW_DEF-1:0] vga_coord_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one display axis. Counts 0..TOTAL-1 on tick and registers
// sync/blank flags from the next count so they line up with count.
// Exposes the next count and the wrap condition for the other axis and the
// window logic.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned CW         = CW_DEF,
  parameter int unsigned TOTAL      = H_TOTAL_DEF,
  parameter int unsigned ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned SYNC_START = H_ACTIVE_DEF + H_FP_DEF,
  parameter int unsigned SYNC_END   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF,
  parameter bit          POL        = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          blnk,
  output logic [CW-1:0] count_nxt_c,
  output logic          wrap_c
);

  // Next count: advance on tick, wrap at TOTAL-1
  always_comb begin
    wrap_c      = tick && (count == CW'(TOTAL - 1));
    count_nxt_c = count;
    if (wrap_c) begin
      count_nxt_c = '0;
    end else if (tick) begin
      count_nxt_c = count + CW'(1);
    end
  end

  // Counter plus flags derived from the value being loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sync  <= ~POL;
      blnk  <= 1'b0;
    end else begin
      count <= count_nxt_c;
      sync  <= ((count_nxt_c >= CW'(SYNC_START)) && (count_nxt_c < CW'(SYNC_END))) ? POL : ~POL;
      blnk  <= (count_nxt_c >= CW'(ACTIVE));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with a frame-shadowed
// display window. All outputs are registered and describe the same
// (hcount, vcount) point.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned WIN_W    = WIN_W_DEF,
  parameter int unsigned WIN_H    = WIN_H_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] win_x0,
  input  logic [CW-1:0] win_y0,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          frame_start,
  output logic          line_end,
  output logic          in_win,
  output logic [CW-1:0] win_x,
  output logic [CW-1:0] win_y
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CW-1:0] h_nxt_c, v_nxt_c;
  logic          h_wrap_c, v_wrap_c;
  logic [CW-1:0] x0_q, y0_q;
  logic [CW-1:0] x0_nxt_c, y0_nxt_c;
  logic          h_in_c, v_in_c, in_win_nxt_c;

  vga_axis_cnt #(
    .CW(CW), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
    .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .POL(HS_POL)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .tick(1'b1),
    .count(hcount), .sync(hsync), .blnk(hblnk),
    .count_nxt_c(h_nxt_c), .wrap_c(h_wrap_c)
  );

  vga_axis_cnt #(
    .CW(CW), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
    .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .POL(VS_POL)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .tick(h_wrap_c),
    .count(vcount), .sync(vsync), .blnk(vblnk),
    .count_nxt_c(v_nxt_c), .wrap_c(v_wrap_c)
  );

  // Window compare on the next point, using the geometry that point will see
  always_comb begin
    x0_nxt_c     = v_wrap_c ? win_x0 : x0_q;
    y0_nxt_c     = v_wrap_c ? win_y0 : y0_q;
    h_in_c       = (h_nxt_c >= x0_nxt_c) &&
                   ({1'b0, h_nxt_c} < ({1'b0, x0_nxt_c} + (CW+1)'(WIN_W))) &&
                   (h_nxt_c < CW'(H_ACTIVE));
    v_in_c       = (v_nxt_c >= y0_nxt_c) &&
                   ({1'b0, v_nxt_c} < ({1'b0, y0_nxt_c} + (CW+1)'(WIN_H))) &&
                   (v_nxt_c < CW'(V_ACTIVE));
    in_win_nxt_c = h_in_c && v_in_c;
  end

  // Shadow window, strobes and window-relative coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q        <= '0;
      y0_q        <= '0;
      frame_start <= 1'b1;
      line_end    <= 1'b0;
      in_win      <= 1'b1;
      win_x       <= '0;
      win_y       <= '0;
    end else begin
      x0_q        <= x0_nxt_c;
      y0_q        <= y0_nxt_c;
      frame_start <= v_wrap_c;
      line_end    <= (h_nxt_c == CW'(H_TOTAL - 1));
      in_win      <= in_win_nxt_c;
      win_x       <= in_win_nxt_c ? (h_nxt_c - x0_nxt_c) : '0;
      win_y       <= in_win_nxt_c ? (v_nxt_c - y0_nxt_c) : '0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Counts frame starts after reset; the reset-held pulse is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (v_wrap_c) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced video mode, checked against a
// positional reference model of the raster and the window rules.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HA = 40, HFP = 4, HSW = 8, HBP = 6;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VA = 20, VFP = 1, VSW = 3, VBP = 4;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int WW = 12, WH = 8;
  localparam logic HP = 1'b1, VP = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  vga_coord_t win_x0, win_y0, hcount, vcount, win_x, win_y;
  logic       hsync, vsync, hblnk, vblnk, frame_start, line_end, in_win;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0, failures = 0;
  int mh, mv, mx0, my0, mfc;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HP), .VS_POL(VP), .WIN_W(WW), .WIN_H(WH), .CW(CW_DEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .win_x0(win_x0), .win_y0(win_y0),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .frame_start(frame_start), .line_end(line_end),
    .in_win(in_win), .win_x(win_x), .win_y(win_y)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: raster position and the frame's window geometry
  function automatic logic e_hs(int h);
    return (h >= HA + HFP && h < HA + HFP + HSW) ? HP : ~HP;
  endfunction
  function automatic logic e_vs(int v);
    return (v >= VA + VFP && v < VA + VFP + VSW) ? VP : ~VP;
  endfunction
  function automatic logic e_in(int h, int v, int x0, int y0);
    return h >= x0 && h < x0 + WW && h < HA && v >= y0 && v < y0 + WH && v < VA;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mx0 = 0; my0 = 0; mfc = 0;
  endtask

  task automatic model_step();
    if (mh == HT - 1 && mv == VT - 1) begin
      mx0 = int'(win_x0);
      my0 = int'(win_y0);
    end
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    if (mh == 0 && mv == 0) mfc = (mfc + 1) % 65536;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic sync_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(mh == 0 && mv == 0) && n < 2 * HT * VT);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    win_x0 = vga_coord_t'($urandom_range(1, HA));
    win_y0 = vga_coord_t'($urandom_range(1, VA));
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (hcount !== '0) begin failures++; $display("FAIL reset_hcount got=%0d exp=0", hcount); end
    checks++; if (vcount !== '0) begin failures++; $display("FAIL reset_vcount got=%0d exp=0", vcount); end
    checks++; if (hsync !== ~HP) begin failures++; $display("FAIL reset_hsync got=%b exp=%b", hsync, ~HP); end
    checks++; if (vsync !== ~VP) begin failures++; $display("FAIL reset_vsync got=%b exp=%b", vsync, ~VP); end
    checks++; if ({hblnk, vblnk} !== 2'b00) begin failures++; $display("FAIL reset_blnk got=%b%b exp=00", hblnk, vblnk); end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL reset_frame_start got=%b exp=1", frame_start); end
    checks++; if (line_end !== 1'b0) begin failures++; $display("FAIL reset_line_end got=%b exp=0", line_end); end
    checks++; if (in_win !== 1'b1) begin failures++; $display("FAIL reset_in_win got=%b exp=1", in_win); end
    checks++; if (win_x !== '0 || win_y !== '0) begin failures++; $display("FAIL reset_win_xy got=%0d,%0d exp=0,0", win_x, win_y); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
`endif
    rst_n = 1'b1;
    step();
    checks++; if (hcount !== vga_coord_t'(1) || vcount !== '0) begin failures++; $display("FAIL first_edge got=(%0d,%0d) exp=(1,0)", hcount, vcount); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL first_edge_fs got=%b exp=0", frame_start); end
  endtask

  task automatic test_counters();
    int fs = 0, le = 0;
    win_x0 = vga_coord_t'($urandom_range(0, HA - 1));
    win_y0 = vga_coord_t'($urandom_range(0, VA - 1));
    repeat (2 * HT * VT) begin
      step();
      checks++; if (hcount !== vga_coord_t'(mh)) begin failures++; $display("FAIL cnt_hcount got=%0d exp=%0d", hcount, mh); end
      checks++; if (vcount !== vga_coord_t'(mv)) begin failures++; $display("FAIL cnt_vcount got=%0d exp=%0d", vcount, mv); end
      checks++; if (hsync !== e_hs(mh)) begin failures++; $display("FAIL cnt_hsync @(%0d,%0d) got=%b exp=%b", mh, mv, hsync, e_hs(mh)); end
      checks++; if (vsync !== e_vs(mv)) begin failures++; $display("FAIL cnt_vsync @(%0d,%0d) got=%b exp=%b", mh, mv, vsync, e_vs(mv)); end
      checks++; if (hblnk !== (mh >= HA)) begin failures++; $display("FAIL cnt_hblnk @(%0d,%0d) got=%b", mh, mv, hblnk); end
      checks++; if (vblnk !== (mv >= VA)) begin failures++; $display("FAIL cnt_vblnk @(%0d,%0d) got=%b", mh, mv, vblnk); end
      checks++; if (frame_start !== (mh == 0 && mv == 0)) begin failures++; $display("FAIL cnt_frame_start @(%0d,%0d) got=%b", mh, mv, frame_start); end
      checks++; if (line_end !== (mh == HT - 1)) begin failures++; $display("FAIL cnt_line_end @(%0d,%0d) got=%b", mh, mv, line_end); end
      checks++; if (in_win !== e_in(mh, mv, mx0, my0)) begin failures++; $display("FAIL cnt_in_win @(%0d,%0d) got=%b", mh, mv, in_win); end
`ifdef VGA_TIMING_FRAME_CNT_EN
      checks++; if (frame_cnt !== 16'(mfc)) begin failures++; $display("FAIL cnt_frame_cnt got=%0d exp=%0d", frame_cnt, mfc); end
`endif
      if (frame_start === 1'b1) fs++;
      if (line_end === 1'b1) le++;
    end
    checks++; if (fs != 2) begin failures++; $display("FAIL frame_start_count got=%0d exp=2", fs); end
    checks++; if (le != 2 * VT) begin failures++; $display("FAIL line_end_count got=%0d exp=%0d", le, 2 * VT); end
  endtask

  task automatic test_window();
    int xt[5], yt[5];
    xt = '{10, HA - 5, HA, 0, HA - 1};
    yt = '{3, VA - 3, 0, 0, VA - WH};
    for (int k = 0; k < 7; k++) begin
      int x0, y0, cw, chh, cnt, fh, fv;
      x0 = (k < 5) ? xt[k] : int'($urandom_range(0, HA + 4));
      y0 = (k < 5) ? yt[k] : int'($urandom_range(0, VA + 2));
      win_x0 = vga_coord_t'(x0);
      win_y0 = vga_coord_t'(y0);
      sync_frame();
      cnt = 0; fh = -1; fv = -1;
      repeat (HT * VT) begin
        checks++; if (in_win !== e_in(mh, mv, mx0, my0)) begin failures++; $display("FAIL win_in_win @(%0d,%0d) got=%b", mh, mv, in_win); end
        checks++; if (win_x !== (e_in(mh, mv, mx0, my0) ? vga_coord_t'(mh - mx0) : '0)) begin failures++; $display("FAIL win_x @(%0d,%0d) got=%0d", mh, mv, win_x); end
        checks++; if (win_y !== (e_in(mh, mv, mx0, my0) ? vga_coord_t'(mv - my0) : '0)) begin failures++; $display("FAIL win_y @(%0d,%0d) got=%0d", mh, mv, win_y); end
        if (in_win === 1'b1) begin
          if (cnt == 0) begin fh = int'(hcount); fv = int'(vcount); end
          cnt++;
        end
        step();
      end
      cw  = (x0 >= HA) ? 0 : ((x0 + WW <= HA) ? WW : HA - x0);
      chh = (y0 >= VA) ? 0 : ((y0 + WH <= VA) ? WH : VA - y0);
      checks++; if (cnt != cw * chh) begin failures++; $display("FAIL win_count x0=%0d y0=%0d got=%0d exp=%0d", x0, y0, cnt, cw * chh); end
      if (cw * chh > 0) begin
        checks++; if (fh != x0 || fv != y0) begin failures++; $display("FAIL win_first got=(%0d,%0d) exp=(%0d,%0d)", fh, fv, x0, y0); end
      end
    end
  endtask

  task automatic test_mid_frame();
    int cnt_a = 0, cnt_b = 0;
    win_x0 = vga_coord_t'(10);
    win_y0 = vga_coord_t'(5);
    sync_frame();
    repeat (HT * VT) begin
      if (mv == 7 && mh == 0) win_x0 = vga_coord_t'(HA - 6);
      checks++; if (in_win !== e_in(mh, mv, mx0, my0)) begin failures++; $display("FAIL mid_cur @(%0d,%0d) got=%b", mh, mv, in_win); end
      if (in_win === 1'b1) cnt_a++;
      step();
    end
    repeat (HT * VT) begin
      checks++; if (in_win !== e_in(mh, mv, mx0, my0)) begin failures++; $display("FAIL mid_next @(%0d,%0d) got=%b", mh, mv, in_win); end
      if (in_win === 1'b1) cnt_b++;
      step();
    end
    checks++; if (cnt_a != WW * WH) begin failures++; $display("FAIL mid_cur_count got=%0d exp=%0d", cnt_a, WW * WH); end
    checks++; if (cnt_b != 6 * WH) begin failures++; $display("FAIL mid_next_count got=%0d exp=%0d", cnt_b, 6 * WH); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    win_x0 = vga_coord_t'($urandom_range(0, HA / 2));
    win_y0 = vga_coord_t'($urandom_range(0, VA / 2));
    while (!(mv == VA / 2 + 1 && mh == HA + HFP + 2) && n < 2 * HT * VT) begin
      step();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hcount !== '0 || vcount !== '0) begin failures++; $display("FAIL async_counts got=(%0d,%0d) exp=(0,0)", hcount, vcount); end
    checks++; if (hsync !== ~HP || vsync !== ~VP) begin failures++; $display("FAIL async_sync got=%b%b exp=%b%b", hsync, vsync, ~HP, ~VP); end
    checks++; if (hblnk !== 1'b0 || frame_start !== 1'b1) begin failures++; $display("FAIL async_flags hblnk=%b fs=%b exp 0,1", hblnk, frame_start); end
    checks++; if (in_win !== 1'b1 || win_x !== '0) begin failures++; $display("FAIL async_win in_win=%b win_x=%0d exp 1,0", in_win, win_x); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (hcount !== '0) begin failures++; $display("FAIL async_hold got=%0d exp=0", hcount); end
    model_reset();
    rst_n = 1'b1;
    step();
    checks++; if (hcount !== vga_coord_t'(1) || vcount !== '0) begin failures++; $display("FAIL async_restart got=(%0d,%0d) exp=(1,0)", hcount, vcount); end
    repeat (2 * HT) begin
      step();
      checks++; if (hcount !== vga_coord_t'(mh) || vcount !== vga_coord_t'(mv)) begin failures++; $display("FAIL async_run got=(%0d,%0d) exp=(%0d,%0d)", hcount, vcount, mh, mv); end
    end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * HT * VT) step();
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL frame_cnt_3 got=%0d exp=3", frame_cnt); end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL frame_cnt_fs got=%b exp=1", frame_start); end
  endtask
`endif

  initial begin
    rst_n  = 1'b1;
    win_x0 = '0;
    win_y0 = '0;
    model_reset();
    test_reset();
    test_counters();
    test_window();
    test_mid_frame();
    test_async_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator. Defaults: 800x600 @ 60 Hz, 40 MHz pixel clock.
- Produces pixel/line counters, sync and blanking, and frame/line strobes.
- Flags a movable display window (default 300x300) and gives window-relative coordinates.
- Sits between the clock/reset block and all draw/overlay stages of the oscilloscope display path.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, active level of hsync
- VS_POL, 1, active level of vsync
- WIN_W, 300, window width
- WIN_H, 300, window height
- CW, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- win_x0  in  CW  requested window left edge (absolute pixel)
- win_y0  in  CW  requested window top edge (absolute line)
- hcount  out  CW  current pixel, 0..H_TOTAL-1
- vcount  out  CW  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- hblnk  out  1  hcount >= H_ACTIVE
- vblnk  out  1  vcount >= V_ACTIVE
- frame_start  out  1  one-cycle pulse at (0,0)
- line_end  out  1  one-cycle pulse at hcount == H_TOTAL-1
- in_win  out  1  current pixel lies in the active window
- win_x  out  CW  hcount - active window x0; 0 when !in_win
- win_y  out  CW  vcount - active window y0; 0 when !in_win

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 1056).
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (default 628).
- Reset (rst_n low, asynchronous):
  - hcount = 0, vcount = 0.
  - hsync = !HS_POL, vsync = !VS_POL.
  - hblnk = 0, vblnk = 0.
  - frame_start = 1, line_end = 0.
  - Active window registers x0 = 0, y0 = 0, so in_win = 1, win_x = 0, win_y = 0.
- After rst_n rises, the first clock edge advances to (1,0).
- Counters:
  - hcount increments each cycle and wraps at H_TOTAL-1 to 0.
  - vcount increments on hcount wrap and wraps at V_TOTAL-1 to 0.
- All outputs are registered and mutually aligned: every flag describes the (hcount, vcount) value presented in the same cycle. There is no skew between counters and flags.
- hsync is active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC. vsync uses the analogous rule on vcount.
- Window shadowing:
  - win_x0/win_y0 are sampled into active window registers only in the cycle whose next state is (0,0), i.e. when the present counter is (H_TOTAL-1, V_TOTAL-1).
  - Changes mid-frame have no effect until the next frame. Window geometry is therefore constant across a frame.
- in_win = (x0 <= hcount < x0+WIN_W) && (y0 <= vcount < y0+WIN_H) && !hblnk && !vblnk.
  - The window is clipped at the visible edge; no wrap-around into blanking or to column 0.
  - Sum x0+WIN_W is computed at CW+1 bits, so there is no overflow for x0 near the top of the range.
- A shadow value of x0 >= H_ACTIVE gives in_win = 0 for the whole frame. This is legal, not an error.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Extra output frame_cnt [15:0]; reset 0.
  - Increments in the same cycle frame_start pulses, except the post-reset pulse.
  - Wraps 0xFFFF -> 0.
- Undefined:
  - Port absent, no counter logic.
  - All other behaviour identical.

Decomposition:
- Extend vga_pkg with:
  - H_/V_ timing constants for the default mode and derived H_TOTAL/V_TOTAL.
  - WIN_W/WIN_H defaults, replacing H_DISPLAY/V_DISPLAY semantics.
  - typedef vga_coord_t = logic [CW-1:0].
- One natural sub-module, vga_axis_cnt:
  - One axis counter with total/sync/blank parameters and a tick-in/wrap-out.
  - Instantiated once for the horizontal axis and once for the vertical axis, with the vertical instance advanced by the horizontal wrap.
- Window compare and shadow registers stay in the top module.

Test Plan:
- Reset then run 1056*628 cycles:
  - hcount wraps 1055 -> 0.
  - vcount wraps 627 -> 0.
  - Exactly one frame_start per 663168 cycles.
  - line_end count = 628 per frame.
- Sync timing:
  - hsync = 1 exactly for hcount 840..967.
  - vsync = 1 exactly for vcount 601..604.
  - hblnk rises at hcount 800; vblnk rises at vcount 600.
- Window, win_x0 = 250, win_y0 = 150 held before frame 2:
  - in_win first at (250,150) with win_x = 0, win_y = 0.
  - Last at (549,449) with win_x = 299, win_y = 299.
  - 90000 in_win cycles per frame.
- Mid-frame change:
  - Change win_x0 to 600 at vcount 200.
  - Current frame keeps x0 = 250.
  - Next frame in_win spans hcount 600..799 only (clipped, 200 per line).
- Async reset:
  - Assert rst_n low at (500,300) for 3 cycles, off-edge.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, sequence restarts from (1,0).
- With VGA_TIMING_FRAME_CNT_EN defined: frame_cnt = 3 after three full frames from reset.
